// File: rtl/subbytes_engine_pkg.sv
// Shared AES definitions: datapath widths, the SubBytes FSM state type and
// GF(2^8) arithmetic used to build the S-box.
package subbytes_engine_pkg;

  localparam int STATE_W = 128;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < BYTE_W; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[BYTE_W-2:0], 1'b0} ^ (x[BYTE_W-1] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
  function automatic logic [BYTE_W-1:0] gf_inv(input logic [BYTE_W-1:0] a);
    logic [BYTE_W-1:0] sq;
    logic [BYTE_W-1:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < BYTE_W; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

endpackage

// File: rtl/subbytes_engine_sbox.sv
// Forward AES S-box, purely combinational; also usable by key expansion.
module aes_sbox
  import subbytes_engine_pkg::*;
(
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout
);

  logic [BYTE_W-1:0] inv;

  // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  always_comb begin
    inv  = gf_inv(din);
    dout = inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  end

endmodule

// File: rtl/subbytes_engine.sv
// Iterative SubBytes engine: substitutes LANES bytes of a 128-bit block per
// cycle, lowest chunk first, and holds the result until the consumer takes it.
module subbytes_engine
  import subbytes_engine_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy,
  output state_e             dbg_state
);

  // Handshake: a block moves across in_* on an edge where in_valid && in_ready,
  // and across out_* on an edge where out_valid && out_ready; in_ready and
  // out_valid are never high together, so a hand-off and an accept never share an edge.

  localparam int STEPS   = 16 / LANES;
  localparam int CHUNK_W = BYTE_W * LANES;
  localparam int CNT_W   = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;

  logic [6:0]         base;
  logic [CHUNK_W-1:0] chunk_in;
  logic [CHUNK_W-1:0] chunk_out;

  // With 16 lanes the step is always 0, so truncating the offset is harmless.
  always_comb begin
    base     = 7'(int'(step_q) * CHUNK_W);
    chunk_in = work_q[base +: CHUNK_W];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox u_sbox (
      .din  (chunk_in[l*BYTE_W +: BYTE_W]),
      .dout (chunk_out[l*BYTE_W +: BYTE_W])
    );
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    work_d      = work_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d     = in_data;
          step_d     = '0;
          state_d    = ST_BUSY;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_BUSY: begin
        work_d[base +: CHUNK_W] = chunk_out;
        step_d = step_q + CNT_W'(1);
        if (step_q == CNT_W'(STEPS - 1)) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        step_d      = '0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      work_q      <= work_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = work_q;
  assign dbg_state = state_q;

endmodule
